// File: rtl/ratio_pkg.sv
// Shared types and constants for the ratio sequencer slice.
// Contents: sequencer state enum, bank/point/accumulator/divider widths,
//           constant divisor and the rounding bias used by the accumulator.
package ratio_pkg;

   localparam int NBANKS     = 10;
   localparam int BANK_W     = 4;
   localparam int PT_W       = 11;
   localparam int ACC_W      = 16;
   localparam int DIV_W      = 20;
   localparam int ROUND_BIAS = 5;

   localparam logic [DIV_W-1:0] DIVISOR = 20'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DIV_START,
      S_DIV_WAIT,
      S_WRITE,
      S_FIN
   } seq_state_t;

   // True on the address of the final bank in a fetch burst.
   function automatic logic is_last_bank(input logic [BANK_W-1:0] b);
      return b == BANK_W'(NBANKS - 1);
   endfunction

endpackage

// File: rtl/ratio_sequencer_if.sv
// Bus bundle between the sequencer, bank storage, shared divider and result buffer.
// master: sequencer side (drives addresses, divider start/operands, result write).
// slave:  environment side (returns bank data, quotient and divider ready).
interface ratio_sequencer_if #(parameter int DW = 12);
   import ratio_pkg::*;

   logic [BANK_W-1:0] rd_bank;
   logic [PT_W-1:0]   rd_point;
   logic [DW-1:0]     rd_data;
   logic              div_start;
   logic [DIV_W-1:0]  div_dividend;
   logic [DIV_W-1:0]  div_divisor;
   logic [DW-1:0]     div_quotient;
   logic              div_ready;
   logic              res_we;
   logic [PT_W-1:0]   res_idx;
   logic [DW-1:0]     res_data;

   modport master (
      output rd_bank, rd_point, div_start, div_dividend, div_divisor,
             res_we, res_idx, res_data,
      input  rd_data, div_quotient, div_ready
   );

   modport slave (
      input  rd_bank, rd_point, div_start, div_dividend, div_divisor,
             res_we, res_idx, res_data,
      output rd_data, div_quotient, div_ready
   );

endinterface

// File: rtl/ratio_acc.sv
// Clear/add accumulator for the ten bank samples of one point.
// Ports: clk, rst (async, active-high), clr, add, din (sample) -> sum (dividend base).
// Macro AVG_ROUND_EN: when defined, sum carries a +5 bias so the /10 rounds half-up.
module ratio_acc
   import ratio_pkg::*;
#(
   parameter int DW = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             add,
   input  logic [DW-1:0]    din,
   output logic [ACC_W-1:0] sum
);

   logic [ACC_W-1:0] acc;

   // 10 * 4095 plus the bias stays below 2^16, so no saturation is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add) begin
         acc <= acc + ACC_W'(din);
      end
   end

`ifdef AVG_ROUND_EN
   assign sum = acc + ACC_W'(ROUND_BIAS);
`else
   assign sum = acc;
`endif

endmodule

// File: rtl/ratio_sequencer.sv
// Point-wise average of 10 measurement banks through one shared external divider.
// Ports: clk, rst (async, active-high), go/switch (start, inhibit), bus (master side of
//        ratio_sequencer_if: bank read, divider, result write), busy/done/overrun status.
// Macro AVG_ROUND_EN (in ratio_acc): rounding average when defined, truncating otherwise.
module ratio_sequencer
   import ratio_pkg::*;
#(
   parameter int POINTS = 500,
   parameter int DW     = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic                switch,
   ratio_sequencer_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   localparam logic [PT_W-1:0] LAST_POINT = PT_W'(POINTS - 1);

   seq_state_t        state, state_n;
   logic [BANK_W-1:0] bank_cnt, bank_n;
   logic [PT_W-1:0]   point, point_n;
   logic [DW-1:0]     quot_q;
   logic              overrun_q;

   logic              acc_clr;
   logic              acc_add;
   logic              quot_cap;
   logic [ACC_W-1:0]  acc_sum;

   ratio_acc #(.DW(DW)) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .add (acc_add),
      .din (bus.rd_data),
      .sum (acc_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         bank_cnt  <= '0;
         point     <= '0;
         quot_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_n;
         bank_cnt  <= bank_n;
         point     <= point_n;
         if (quot_cap) begin
            quot_q <= bus.div_quotient;
         end
         // Any go outside IDLE (FIN included) is refused and flagged next cycle.
         overrun_q <= go && (state != S_IDLE);
      end
   end

   always_comb begin
      state_n          = state;
      bank_n           = bank_cnt;
      point_n          = point;
      acc_clr          = 1'b0;
      acc_add          = 1'b0;
      quot_cap         = 1'b0;
      bus.rd_bank      = '0;
      bus.rd_point     = '0;
      bus.div_start    = 1'b0;
      bus.div_dividend = '0;
      bus.div_divisor  = DIVISOR;
      bus.res_we       = 1'b0;
      bus.res_idx      = '0;
      bus.res_data     = '0;
      busy             = 1'b0;
      done             = 1'b0;
      overrun          = overrun_q;

      case (state)
         S_IDLE: begin
            if (go && !switch) begin
               state_n = S_FETCH;
               bank_n  = '0;
               point_n = '0;
               acc_clr = 1'b1;
            end
         end

         S_FETCH: begin
            busy         = 1'b1;
            bus.rd_bank  = bank_cnt;
            bus.rd_point = point;
            // Read data lags the address by one cycle: the first fetch cycle has
            // nothing to add yet, and bank 9's data lands during DRAIN.
            acc_add      = (bank_cnt != '0);
            if (is_last_bank(bank_cnt)) begin
               bank_n  = '0;
               state_n = S_DRAIN;
            end else begin
               bank_n  = bank_cnt + 1'b1;
            end
         end

         S_DRAIN: begin
            busy    = 1'b1;
            acc_add = 1'b1;
            state_n = S_DIV_START;
         end

         S_DIV_START: begin
            busy             = 1'b1;
            bus.div_start    = 1'b1;
            bus.div_dividend = DIV_W'(acc_sum);
            state_n          = S_DIV_WAIT;
         end

         S_DIV_WAIT: begin
            busy             = 1'b1;
            bus.div_dividend = DIV_W'(acc_sum);
            if (bus.div_ready) begin
               quot_cap = 1'b1;
               state_n  = S_WRITE;
            end
         end

         S_WRITE: begin
            busy             = 1'b1;
            bus.div_dividend = DIV_W'(acc_sum);
            bus.res_we       = 1'b1;
            bus.res_idx      = point;
            bus.res_data     = quot_q;
            if (point == LAST_POINT) begin
               state_n = S_FIN;
            end else begin
               point_n = point + 1'b1;
               acc_clr = 1'b1;
               state_n = S_FETCH;
            end
         end

         S_FIN: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ratio_sequencer.sv
// Bench for ratio_sequencer with POINTS=4: bank memory and divider models,
// expected results queued by the stimulus and popped by a separate monitor.
module tb_ratio_sequencer;
   import ratio_pkg::*;

   localparam int DW = 12;
   localparam int NP = 4;
`ifdef AVG_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic go = 1'b0;
   logic switch = 1'b0;
   logic busy, done, overrun;

   ratio_sequencer_if #(.DW(DW)) bus ();

   ratio_sequencer #(.POINTS(NP), .DW(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .switch  (switch),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bank storage: registered read, data valid one cycle after the address.
   logic [DW-1:0] mem [NBANKS][NP];
   always @(posedge clk) begin
      if (int'(bus.rd_bank) < NBANKS && int'(bus.rd_point) < NP)
         bus.rd_data <= mem[int'(bus.rd_bank)][int'(bus.rd_point)];
      else
         bus.rd_data <= '0;
   end

   // Divider: ready pulses div_lat cycles after the start pulse.
   int div_lat = 3;
   int dcnt;
   logic [DIV_W-1:0] dq;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt <= 0;
         bus.div_ready <= 1'b0;
         bus.div_quotient <= '0;
      end else begin
         bus.div_ready <= 1'b0;
         if (bus.div_start) begin
            dcnt <= div_lat;
            dq <= bus.div_dividend / bus.div_divisor;
         end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
               bus.div_ready <= 1'b1;
               bus.div_quotient <= dq[DW-1:0];
            end
         end
      end
   end

   typedef struct packed {
      logic [PT_W-1:0] idx;
      logic [DW-1:0]   dat;
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input int idx, input int dat);
      exp_t e;
      e.idx = PT_W'(idx);
      e.dat = DW'(dat);
      sb.push_back(e);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: scoreboard pops and protocol timing checks.
   int   go_cyc = 0;
   bit   lat_armed = 1'b0;
   logic prev_ready = 1'b0;
   logic prev_dstart = 1'b0;
   int   dstart_cnt = 0;
   int   done_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.res_we) begin
            check("res_we_after_ready", prev_ready, 1);
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_write: idx %0d data %0d, expected no write", bus.res_idx, bus.res_data);
            end else begin
               e = sb.pop_front();
               check("res_idx", bus.res_idx, e.idx);
               check("res_data", bus.res_data, e.dat);
            end
         end
         if (bus.div_start) begin
            check("div_start_width", prev_dstart, 0);
            dstart_cnt++;
            if (lat_armed) begin
               check("go_to_div_start", cyc - go_cyc, 12);
               lat_armed = 1'b0;
            end
         end
         if (go && !switch && !busy && !done) begin
            go_cyc = cyc;
            lat_armed = 1'b1;
         end
         if (done) done_cnt++;
      end
      prev_ready = bus.div_ready;
      prev_dstart = bus.div_start;
   end

   task automatic pulse_go();
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      check("done_seen", seen, 1);
   endtask

   task automatic wait_dstart(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = bus.div_start;
      end
      check("div_start_seen", seen, 1);
   endtask

   // Pattern 0: bank b, point p = p+1.  Pattern 1: mixed boundary data.
   task automatic load_mem(input int pat);
      for (int b = 0; b < NBANKS; b++) begin
         for (int p = 0; p < NP; p++) begin
            if (pat == 0) mem[b][p] = DW'(p + 1);
            else begin
               case (p)
                  0: mem[b][p] = 12'd4095;
                  1: mem[b][p] = (b == 9) ? 12'd5 : 12'd0;
                  2: mem[b][p] = DW'(b);
                  default: mem[b][p] = 12'd7;
               endcase
            end
         end
      end
   endtask

   initial begin
      int busy_seen;
      int dstart_before;

      load_mem(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_div_start", bus.div_start, 0);
      check("rst_res_we", bus.res_we, 0);
      check("rst_rd_bank", bus.rd_bank, 0);
      check("rst_rd_point", bus.rd_point, 0);
      check("rst_dividend", bus.div_dividend, 0);
      check("rst_divisor", bus.div_divisor, 10);
      check("rst_res_data", bus.res_data, 0);
      rst = 1'b0;

      // Run 1: ramp data, short divider latency.
      for (int p = 0; p < NP; p++) push_exp(p, p + 1);
      pulse_go();
      wait_done(2000);
      repeat (5) @(negedge clk);
      check("done_count_run1", done_cnt, 1);
      check("sb_empty_run1", sb.size(), 0);
      check("dstart_count_run1", dstart_cnt, 4);

      // Run 2: full-scale, rounding and mixed points; slow divider; go during DIV_WAIT.
      load_mem(1);
      div_lat = 37;
      push_exp(0, 4095);
      push_exp(1, RND ? 1 : 0);
      push_exp(2, RND ? 5 : 4);
      push_exp(3, 7);
      pulse_go();
      wait_dstart(100);
      check("dividend_full_scale", bus.div_dividend, RND ? 40955 : 40950);
      repeat (2) @(posedge clk);
      #1 go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      @(negedge clk);
      check("overrun_pulse", overrun, 1);
      check("busy_during_overrun", busy, 1);
      @(negedge clk);
      check("overrun_one_cycle", overrun, 0);
      wait_done(2000);
      repeat (5) @(negedge clk);
      check("done_count_run2", done_cnt, 2);
      check("sb_empty_run2", sb.size(), 0);
      check("dstart_count_run2", dstart_cnt, 8);

      // Run 3: go inhibited by switch.
      switch = 1'b1;
      pulse_go();
      busy_seen = 0;
      dstart_before = dstart_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || bus.rd_bank != '0) busy_seen++;
      end
      check("switch_no_activity", busy_seen, 0);
      check("switch_no_div_start", dstart_cnt, dstart_before);
      @(posedge clk); #1 switch = 1'b0;

      // Run 4: reset in DIV_WAIT, then a clean restart from point 0 with switch toggled mid-run.
      load_mem(0);
      div_lat = 5;
      pulse_go();
      wait_dstart(100);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_dividend", bus.div_dividend, 0);
      check("arst_res_we", bus.res_we, 0);
      check("arst_rd_bank", bus.rd_bank, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int p = 0; p < NP; p++) push_exp(p, p + 1);
      pulse_go();
      repeat (3) @(posedge clk);
      #1 switch = 1'b1;
      wait_done(2000);
      #1 switch = 1'b0;
      repeat (5) @(negedge clk);
      check("done_count_run4", done_cnt, 3);
      check("sb_empty_run4", sb.size(), 0);
      check("dstart_count_run4", dstart_cnt, 13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
